mem_port_arbiter: RTL

- Shares the core's single memory port between three requesters: 0 = instruction fetch, 1 = load/store, 2 = AMO/debug.
- Drives the 2-bit select of the mux_3x1 that steers address, write-data and control onto the port, plus the port valid strobe.
- Provides round-robin (or fixed-priority) arbitration, multi-transaction locking for atomic read-modify-write, and a no-response watchdog.

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_port_arbiter_pick.sv | 31 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter and the memory-stage mux_3x1.
package mem_port_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BUSY   = 2'b01,
    ARB_LOCKED = 2'b10
  } arb_state_e;

  // mux_3x1 select encodings; SEL_IDLE makes the mux drive zero.
  localparam logic [1:0] SEL_REQ0 = 2'b00;
  localparam logic [1:0] SEL_REQ1 = 2'b01;
  localparam logic [1:0] SEL_REQ2 = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  // Select code to one-hot requester mask (SEL_IDLE -> no requester).
  function automatic logic [2:0] sel_to_onehot(input logic [1:0] s);
    logic [2:0] oh;
    case (s)
      SEL_REQ0: oh = 3'b001;
      SEL_REQ1: oh = 3'b010;
      SEL_REQ2: oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Next requester index modulo 3; an out-of-range code wraps to 0.
  function automatic logic [1:0] idx_next(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// rr_pick3: combinational three-way picker. Searches from the round-robin
// pointer (or always from requester 0 in fixed-priority mode) and returns
// the first requester found.
module rr_pick3
  import mem_port_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       valid_o,
  output logic [1:0] win_o
);

  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  // Build the search order, then take the first candidate that is requesting.
  always_comb begin
    cand0   = (FIXED_PRIO || ptr_i == SEL_IDLE) ? SEL_REQ0 : ptr_i;
    cand1   = idx_next(cand0);
    cand2   = idx_next(cand1);
    valid_o = |req_i;
    if (|(req_i & sel_to_onehot(cand0)))      win_o = cand0;
    else if (|(req_i & sel_to_onehot(cand1))) win_o = cand1;
    else if (|(req_i & sel_to_onehot(cand2))) win_o = cand2;
    else                                      win_o = SEL_IDLE;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch
// (0), load/store (1) and AMO/debug (2). Drives the mux_3x1 select, the
// one-hot grant and the port valid strobe; supports bus locking for atomic
// read-modify-write and a no-response watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] lock,
  input  logic       mem_ready,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       mem_valid,
  output logic [2:0] done,
  output logic       err
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             mem_valid_q, mem_valid_d;
  logic             err_q, err_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       owner_d;

  logic             owner_lock;
  logic             owner_req;
  logic             wd_expire;
  logic [1:0]       ptr_after;
  logic [1:0]       pick_ptr;
  logic             pick_valid;
  logic [1:0]       pick_win;

  // The current owner is the registered select; gnt_q is its one-hot form.
  assign owner_lock = |(lock & gnt_q);
  assign owner_req  = |(req & gnt_q);
  assign ptr_after  = idx_next(sel_q);
  assign wd_expire  = (TIMEOUT != 0) && (state_q == ARB_BUSY) && !mem_ready
                      && (cnt_q == CNT_MAX);

  // From IDLE the search starts at the stored pointer; when releasing an
  // owner it starts just past that owner, so the advance and the
  // re-arbitration happen at the same edge.
  assign pick_ptr = (state_q == ARB_IDLE) ? ptr_q : ptr_after;

  rr_pick3 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .win_o   (pick_win)
  );

  // State, pointer, watchdog and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= 3'b000;
      sel_q       <= SEL_IDLE;
      mem_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      mem_valid_q <= mem_valid_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic: arbitration, completion, locking and watchdog abort.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    owner_d = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_BUSY;
          owner_d = pick_win;
          cnt_d   = '0;
        end
      end
      ARB_BUSY: begin
        if (mem_ready) begin
          cnt_d = '0;
          if (owner_lock) begin
            state_d = ARB_LOCKED;
          end else begin
            ptr_d   = ptr_after;
            state_d = pick_valid ? ARB_BUSY : ARB_IDLE;
            owner_d = pick_valid ? pick_win : SEL_IDLE;
          end
        end else if (wd_expire) begin
          // Abort: no completion, any lock request is dropped.
          err_d   = 1'b1;
          ptr_d   = ptr_after;
          state_d = ARB_IDLE;
          owner_d = SEL_IDLE;
          cnt_d   = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_LOCKED: begin
        if (owner_req) begin
          state_d = ARB_BUSY;
        end else if (!owner_lock) begin
          ptr_d   = ptr_after;
          state_d = pick_valid ? ARB_BUSY : ARB_IDLE;
          owner_d = pick_valid ? pick_win : SEL_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = SEL_IDLE;
      end
    endcase
  end

  // Output decode for the registered port controls from the next state.
  always_comb begin
    sel_d       = owner_d;
    gnt_d       = sel_to_onehot(owner_d);
    mem_valid_d = (state_d == ARB_BUSY);
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign mem_valid = mem_valid_q;
  assign err       = err_q;
  assign done      = gnt_q & {3{mem_valid_q & mem_ready}};

endmodule
